dc_offset_remover: RTL and testbench

- Upstream stage of the autocorrelation period detector.
- Takes raw unsigned ADC samples and estimates the DC level as the block mean of 2^LOG2_N samples.
- Outputs signed, mean-removed samples with a valid strobe and a level `en` that gates the detector.
- The mean is re-estimated every block, so slow drift is tracked with one block of lag.

---
 rtl/dc_offset_remover_if.sv | 22 ++
 rtl/dc_offset_remover.sv | 86 ++++++++
 tb/tb_dc_offset_remover.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dc_offset_remover_if.sv
// Sample stream bus between the ADC front end and the DC offset remover.
// The master drives raw samples; the slave returns centred samples and the mean estimate.
interface dc_offset_remover_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  en;
  logic [DATA_WIDTH-1:0] mean_out;

  modport master (
    output in_valid, data_in,
    input  data_out, out_valid, en, mean_out
  );

  modport slave (
    input  in_valid, data_in,
    output data_out, out_valid, en, mean_out
  );
endinterface

// File: rtl/dc_offset_remover.sv
// Block-mean DC estimator and remover ahead of the autocorrelation period detector.
// state   | meaning
// ACQUIRE | collecting the first block, no output, en low
// RUN     | centring each sample with the previous block mean, next block accumulating
module dc_offset_remover #(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = 10   // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  dc_offset_remover_if.slave bus
);

  localparam int AW = DATA_WIDTH + LOG2_N;
  localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_N - 1);

  typedef enum logic {ACQUIRE, RUN} state_e;

  state_e                state_q;
  logic [AW-1:0]         acc_q;
  logic [LOG2_N-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0] mean_q;
  logic                  en_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic [AW-1:0]         acc_sum;
  logic [AW:0]           acc_rnd;
  logic [DATA_WIDTH:0]   mean_full;
  logic [DATA_WIDTH-1:0] mean_d;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] data_out_d;

  always_comb begin
    acc_sum   = acc_q + AW'(bus.data_in);
    acc_rnd   = {1'b0, acc_sum} + HALF;
    mean_full = (DATA_WIDTH+1)'(acc_rnd >> LOG2_N);
    mean_d    = mean_full[DATA_WIDTH] ? '1 : mean_full[DATA_WIDTH-1:0];

    // Differences of two unsigned values fit in DATA_WIDTH+1 bits two's complement
    diff = {1'b0, bus.data_in} - {1'b0, mean_q};
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
      data_out_d = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      data_out_d = diff[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACQUIRE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mean_q      <= '0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        // Centred with the mean in force before this edge, even on a block's last sample
        if (state_q == RUN) begin
          out_valid_q <= 1'b1;
          data_out_q  <= data_out_d;
        end
        if (&cnt_q) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          mean_q  <= mean_d;
          en_q    <= 1'b1;
          state_q <= RUN;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.en        = en_q;
  assign bus.mean_out  = mean_q;

endmodule

// File: tb/tb_dc_offset_remover.sv
// Directed bench for dc_offset_remover with default parameters (12-bit, N = 1024).
module tb_dc_offset_remover;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  dc_offset_remover_if #(.DATA_WIDTH(12)) bus ();

  dc_offset_remover #(.DATA_WIDTH(12), .LOG2_N(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int dout();
    return int'($signed(bus.data_out));
  endfunction

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic cycle(input logic vld, input int d);
    bus.in_valid = vld;
    bus.data_in  = 12'(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic feed(input int n, input int v, input int exp_d,
                      output int ov_cnt, output int bad);
    ov_cnt = 0;
    bad    = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, v);
      if (bus.out_valid) begin
        ov_cnt++;
        if (dout() != exp_d) bad++;
      end
    end
  endtask

  int ov, bad, stray, hold_bad;
  int sat_in [4];
  int sat_exp[4];

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_data_out",  int'(bus.data_out), 0);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_en",        int'(bus.en), 0);
    check_eq("rst_mean",      int'(bus.mean_out), 0);
    rst = 1'b0;

    // Constant 2048, 1100 back-to-back samples
    feed(1023, 2048, 0, ov, bad);
    check_eq("t1_ov_acquire", ov, 0);
    check_eq("t1_en_before",  int'(bus.en), 0);
    cycle(1'b1, 2048);
    check_eq("t1_en_rise",    int'(bus.en), 1);
    check_eq("t1_mean",       int'(bus.mean_out), 2048);
    check_eq("t1_ov_1024",    int'(bus.out_valid), 0);
    feed(76, 2048, 0, ov, bad);
    check_eq("t1_run_ov",     ov, 76);
    check_eq("t1_run_dout",   bad, 0);
    cycle(1'b0, 0);
    check_eq("t1_ov_pulse",   int'(bus.out_valid), 0);

    // Alternating 1000/1001
    do_reset();
    ov = 0; bad = 0;
    for (int i = 0; i < 2048; i++) begin
      cycle(1'b1, 1000 + (i % 2));
      if (i == 1023) check_eq("t2_mean_first", int'(bus.mean_out), 1001);
      if (bus.out_valid) begin
        ov++;
        if (dout() != (1000 + (i % 2)) - 1001) bad++;
      end
    end
    check_eq("t2_ov",         ov, 1024);
    check_eq("t2_dout",       bad, 0);
    check_eq("t2_mean_final", int'(bus.mean_out), 1001);

    // Half-up rounding of the mean
    do_reset();
    feed(1023, 0, 0, ov, bad);
    cycle(1'b1, 512);
    check_eq("rnd_half_up", int'(bus.mean_out), 1);
    feed(1023, 0, -1, ov, bad);
    check_eq("rnd_dout", bad, 0);
    cycle(1'b1, 511);
    check_eq("rnd_last_dout", dout(), 510);
    check_eq("rnd_below_half", int'(bus.mean_out), 0);

    // Positive saturation around mean 100
    do_reset();
    feed(1024, 100, 0, ov, bad);
    check_eq("satp_mean", int'(bus.mean_out), 100);
    sat_in  = '{4095, 2147, 2148, 2146};
    sat_exp = '{2047, 2047, 2047, 2046};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, sat_in[i]);
      check_eq($sformatf("satp_%0d", sat_in[i]), dout(), sat_exp[i]);
    end

    // Negative saturation around mean 4000
    do_reset();
    feed(1024, 4000, 0, ov, bad);
    check_eq("satn_mean", int'(bus.mean_out), 4000);
    sat_in  = '{0, 1952, 1951, 4095};
    sat_exp = '{-2048, -2048, -2048, 95};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, sat_in[i]);
      check_eq($sformatf("satn_%0d", sat_in[i]), dout(), sat_exp[i]);
    end

    // Mean tracking 500 -> 700
    do_reset();
    feed(1024, 500, 0, ov, bad);
    feed(1023, 700, 200, ov, bad);
    check_eq("trk_ov",       ov, 1023);
    check_eq("trk_dout",     bad, 0);
    check_eq("trk_mean_old", int'(bus.mean_out), 500);
    cycle(1'b1, 700);
    check_eq("trk_last_dout", dout(), 200);
    check_eq("trk_mean_new",  int'(bus.mean_out), 700);
    cycle(1'b1, 700);
    check_eq("trk_next_dout", dout(), 0);

    // Sparse ramp, one valid every 20 cycles, mean 700
    ov = 0; bad = 0; stray = 0; hold_bad = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 700 + 5 * k);
      if (bus.out_valid) ov++;
      if (!bus.out_valid || dout() != 5 * k) bad++;
      for (int j = 0; j < 19; j++) begin
        cycle(1'b0, 0);
        if (bus.out_valid) stray++;
        if (dout() != 5 * k) hold_bad++;
      end
    end
    check_eq("sp_ov_count", ov, 20);
    check_eq("sp_lag",      bad, 0);
    check_eq("sp_stray",    stray, 0);
    check_eq("sp_hold",     hold_bad, 0);

    // Reset at sample 1500 coincident with a valid sample
    do_reset();
    feed(1499, 300, 0, ov, bad);
    rst = 1'b1;
    cycle(1'b1, 300);
    rst = 1'b0;
    check_eq("mr_en",   int'(bus.en), 0);
    check_eq("mr_mean", int'(bus.mean_out), 0);
    check_eq("mr_ov",   int'(bus.out_valid), 0);
    feed(1023, 800, 0, ov, bad);
    check_eq("mr_en_hold", int'(bus.en), 0);
    check_eq("mr_ov_acq",  ov, 0);
    cycle(1'b1, 800);
    check_eq("mr_en_rise", int'(bus.en), 1);
    check_eq("mr_mean_new", int'(bus.mean_out), 800);
    cycle(1'b1, 800);
    check_eq("mr_dout", dout(), 0);
    cycle(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
